// File: rtl/seq_signed_multiplier_pkg.sv
// Shared arithmetic helpers and FSM state type for the sequential mul/div blocks.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package seq_signed_multiplier_pkg;

  // Widest operand the helpers support; callers zero-extend into these widths
  // and truncate the result back to their own WIDTH.
  localparam int MAX_W = 16;
  localparam int IDX_W = $clog2(MAX_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Unsigned magnitude of a width-bit two's-complement value. The most
  // negative value maps to 2^(width-1), which still fits in width bits.
  function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] value,
                                               input int width);
    logic [MAX_W-1:0] mask;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    if (value[IDX_W'(width - 1)]) begin
      abs_mag = (~value + MAX_W'(1)) & mask;
    end else begin
      abs_mag = value & mask;
    end
  endfunction

  // Two's-complement negate; callers keep the low bits they need.
  function automatic logic [2*MAX_W-1:0] neg2c(input logic [2*MAX_W-1:0] value);
    neg2c = ~value + (2*MAX_W)'(1);
  endfunction

endpackage

// File: rtl/seq_signed_multiplier_if.sv
// Start/done bus of the sequential signed multiplier.
// Latency: n/a (wiring only).
// Backpressure: none; start is a pulse, honoured only while the block is idle.
// master: start, multiplicand, multiplier out; busy, done, product in.
// slave : mirror of master.
interface seq_signed_multiplier_if #(
  parameter int WIDTH = 8
);
  import seq_signed_multiplier_pkg::*;

  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );

endinterface

// File: rtl/seq_signed_multiplier.sv
// Sequential signed shift-add multiplier: 2*WIDTH-bit product of two signed operands.
// Latency: done pulses WIDTH+1 cycles after the accepted start edge; one result per WIDTH+2 cycles.
// Backpressure: start is ignored (not queued) while busy; product holds until the next done.
// Ports: clk, rst_n (async active-low); bus (slave): start, multiplicand, multiplier in;
//        busy, done, product out (all registered).
module seq_signed_multiplier
  import seq_signed_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_signed_multiplier_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               sign_q, sign_d;
  // {hi[WIDTH:0], lo[WIDTH-1:0]}; lo starts as |B| and is consumed LSB first
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0]     hi_sum;
  logic [2*WIDTH-1:0] mag;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;

    // hi is one bit wider than |A|, so this add can never overflow
    hi_sum = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
    mag    = acc_q[2*WIDTH-1:0];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = WIDTH'(abs_mag(MAX_W'(bus.multiplicand), WIDTH));
          acc_d   = {(WIDTH+1)'(0), WIDTH'(abs_mag(MAX_W'(bus.multiplier), WIDTH))};
          sign_d  = bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (acc_q[0]) begin
          acc_d = {1'b0, hi_sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = acc_q >> 1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        // zero magnitude stays zero regardless of the operand signs
        if (sign_q && (mag != '0)) begin
          product_d = (2*WIDTH)'(neg2c((2*MAX_W)'(mag)));
        end else begin
          product_d = mag;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      sign_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      sign_q    <= sign_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Scoreboard bench for seq_signed_multiplier: randomized and directed operations.
// Expected products come from plain signed arithmetic; a monitor pops on each done.
module tb_seq_signed_multiplier;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_signed_multiplier_if #(.WIDTH(W)) bus ();

  seq_signed_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_prod = '0;
  logic [2*W-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return (2*W)'(p);
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'h00;
      3:       return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: every done pops one expectation; between dones the product must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_prod = '0;
    end else if (bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("product", 32'(bus.product), 32'(mon_exp));
      end
      last_prod = bus.product;
    end else begin
      check("product_hold", 32'(bus.product), 32'(last_prod));
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the edge that raised done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    int lat;
    bit got;
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    exp_q.push_back(ref_mul(a, b));
    @(posedge clk); #1;
    bus.start        = 1'b0;
    bus.multiplicand = W'($urandom);
    bus.multiplier   = W'($urandom);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (inject && lat == 2) begin
        bus.start        = 1'b1;
        bus.multiplicand = 8'd100;
        bus.multiplier   = 8'd100;
      end
      if (inject && lat == 3) bus.start = 1'b0;
      if (bus.done) got = 1'b1;
      else check("busy_during_op", 32'(bus.busy), 32'd1);
    end
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(W + 1));
    check("busy_at_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int seen;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_product", 32'(bus.product), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // directed cases with hand-computed results
    run_op(8'd7, 8'd9, 1'b0);
    check("prod_7x9", 32'(bus.product), 32'h003F);
    idle_cycles(1);
    run_op(8'hFB, 8'd3, 1'b0);
    check("prod_m5x3", 32'(bus.product), 32'hFFF1);
    idle_cycles(2);
    run_op(8'h80, 8'h7F, 1'b0);
    check("prod_m128x127", 32'(bus.product), 32'hC080);
    idle_cycles(1);
    run_op(8'h80, 8'h80, 1'b0);
    check("prod_m128xm128", 32'(bus.product), 32'h4000);
    idle_cycles(1);
    run_op(8'h00, 8'hFF, 1'b0);
    check("prod_0xm1", 32'(bus.product), 32'h0000);
    idle_cycles(1);

    // second start mid-operation must be ignored
    run_op(8'd2, 8'd3, 1'b1);
    check("prod_ignored_start", 32'(bus.product), 32'h0006);
    // start in the done cycle is accepted
    run_op(8'hFF, 8'hFF, 1'b0);
    check("prod_back_to_back", 32'(bus.product), 32'h0001);
    idle_cycles(2);

    // reset in the middle of an operation
    bus.start        = 1'b1;
    bus.multiplicand = 8'd55;
    bus.multiplier   = 8'd77;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idle_cycles(3);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_product", 32'(bus.product), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    check("no_done_after_reset", 32'(seen), 32'd0);
    run_op(8'd12, 8'hF4, 1'b0);
    check("prod_12xm12", 32'(bus.product), 32'hFF70);
    idle_cycles(1);

    // randomized operations, mixing back-to-back and idle gaps
    for (int i = 0; i < 40; i++) begin
      run_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 3) == 0));
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_signed_multiplier.md
Name: seq_signed_multiplier

Overview:
Sequential signed shift-add multiplier. It is the multiply counterpart to the team's sequential signed divider. It takes two WIDTH-bit two's-complement operands on a start pulse and computes the 2*WIDTH-bit signed product over WIDTH iteration cycles. The result is reported with a one-cycle done pulse. It sits beside the divider in the arithmetic datapath and shares the same start/done handshake style, except that start is a pulse rather than a held level.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits; legal range 2..16.

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
multiplicand  input  WIDTH  signed operand A; sampled on the accepted start edge.
multiplier  input  WIDTH  signed operand B; sampled on the accepted start edge.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when product is valid.
product  output  2*WIDTH  signed A*B; holds last result until next done.

Behaviour:
- Reset (asynchronous): rst_n is asynchronous, active-low; clock is clk.
  - Reset values: state=IDLE, busy=0, done=0, product=0, all internal registers=0.
  - Reset mid-operation aborts the operation with no done pulse.
- State machine: IDLE -> CALC -> FIN -> IDLE.
- IDLE, start=1 at edge T0:
  - Latch |A| and |B| as unsigned WIDTH-bit magnitudes. The most-negative value maps to 2^(WIDTH-1), e.g. -128 -> 0x80.
  - Latch sign = A[msb] ^ B[msb].
  - Clear the accumulator; iteration counter=0; busy=1; go to CALC.
- CALC, exactly WIDTH cycles, edges T0+1 .. T0+WIDTH:
  - Accumulator is {hi[WIDTH:0], lo[WIDTH-1:0]}, with lo initialised to |B|.
  - Each cycle: if lo[0], hi = hi + |A| (WIDTH+1-bit add, no overflow possible).
  - Then shift the whole accumulator right by 1.
  - Counter increments; after the WIDTH-th iteration go to FIN.
- FIN, edge T0+WIDTH+1:
  - product = sign ? -(magnitude) : magnitude, where magnitude = low 2*WIDTH bits of the accumulator.
  - A zero magnitude always yields 0.
  - done=1 for this one cycle; busy=0; state=IDLE.
- Latency and busy timing:
  - done goes high WIDTH+1 cycles after the accepted start edge (9 cycles for WIDTH=8).
  - busy is high from T0 up to, not including, the FIN edge.
- start while busy: ignored, not queued; operands not re-sampled.
- start in the cycle done is high: accepted, because the state is already IDLE. This gives back-to-back throughput of one result per WIDTH+2 cycles.
- Operand changes after the accepted start edge have no effect on the result.
- Range: the magnitude fits 2*WIDTH bits. The worst case (-2^(W-1))^2 = 2^(2W-2) is positive and fits, so no overflow flag is needed.
- done and product are registered outputs with no combinational path from inputs.

Decomposition:
- Shared arithmetic package:
  - state enum type {IDLE, CALC, FIN}.
  - Function abs_mag(value, WIDTH), returning an unsigned magnitude.
  - Function neg2c(value), returning the two's-complement negate.
  - The signed divider uses the same abs/negate helpers.
- No sub-module: a single FSM plus datapath is natural.
- Counter width is $clog2(WIDTH+1).

Test Plan:
1. A=7, B=9, start pulse -> done after 9 cycles, product=0x003F; busy high for 9 cycles before done.
2. A=-5 (0xFB), B=3 -> product=0xFFF1 (-15). A=-128, B=127 -> product=0xC080 (-16256).
3. A=-128, B=-128 -> product=0x4000 (+16384). A=0, B=-1 -> product=0x0000.
4. start with A=2, B=3, then start again with A=100, B=100 at cycle 3 -> second request ignored; product=0x0006 at the single done.
5. start asserted in the same cycle done is high, with A=-1, B=-1 -> previous product held until the next done; next done WIDTH+1 cycles later with product=0x0001.
6. rst_n asserted at cycle 4 of an operation -> busy, done and product all 0 immediately; no done pulse afterwards; a fresh start with A=12, B=-12 -> product=0xFF70 (-144).
